// File: rtl/phy_clk_gate_ctrl.sv
// Multi-channel PHY clock-gate controller: request synchroniser,
// per-channel wake/ack/hold-off sequencing and latch-based clock gates.
module phy_clk_gate_ctrl #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              scanen,
  input  logic [NCH-1:0]    req,
  input  logic [HOLD_W-1:0] hold_val,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    clk_out,
  output logic              all_idle
);

  localparam int CW = (HOLD_W > 4) ? HOLD_W : 4;

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_HOLD
  } state_t;

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] req_s;

  state_t        state_q [NCH];
  state_t        state_d [NCH];
  logic [CW-1:0] cnt_q   [NCH];
  logic [CW-1:0] cnt_d   [NCH];

  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] gate_q, gate_d;
  logic           all_idle_q, all_idle_d;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    all_idle_d = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ack_d[i]   = ack_q[i];
      unique case (state_q[i])
        S_OFF: begin
          if (req_s[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = CW'(WAKE_CYCLES - 1);
          end
        end
        // a wake always runs to completion
        S_WAKE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_ON;
            ack_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        S_ON: begin
          if (!req_s[i]) begin
            state_d[i] = S_HOLD;
            cnt_d[i]   = CW'(hold_val);
          end
        end
        S_HOLD: begin
          if (req_s[i]) begin
            state_d[i] = S_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = S_OFF;
            ack_d[i]   = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: state_d[i] = S_OFF;
      endcase
      if (state_d[i] != S_OFF) all_idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      ack_q      <= '0;
      all_idle_q <= 1'b1;
    end else begin
      sync_q[0] <= req;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ack_q      <= ack_d;
      all_idle_q <= all_idle_d;
    end
  end

  always_comb begin
    gate_d = '0;
    for (int i = 0; i < NCH; i++) begin
      gate_d[i] = (state_q[i] != S_OFF) | scanen;
    end
  end

  // enable only moves while clk_in is low, so no pulse is ever cut short
  always_latch begin
    if (!rst_n) begin
      gate_q = '0;
    end else if (!clk_in) begin
      gate_q = gate_d;
    end
  end

  assign clk_out  = {NCH{clk_in}} & gate_q;
  assign ack      = ack_q;
  assign all_idle = all_idle_q;

endmodule

// File: tb/tb_phy_clk_gate_ctrl.sv
// Randomised scoreboard bench for phy_clk_gate_ctrl against an
// event-level reference model of the channel sequencing.
module tb_phy_clk_gate_ctrl;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int WC  = 2;
  localparam int HW  = 8;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b1;
  logic          scanen = 1'b0;
  logic [NCH-1:0] req   = '0;
  logic [HW-1:0] hold_val = 8'd2;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] clk_out;
  logic          all_idle;

  phy_clk_gate_ctrl #(
    .NCH(NCH), .SYNC_STAGES(SS),
    .WAKE_CYCLES(WC), .HOLD_W(HW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .scanen(scanen), .req(req),
    .hold_val(hold_val), .ack(ack),
    .clk_out(clk_out), .all_idle(all_idle)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NCH-1:0] ack;
    logic           idle;
    logic [NCH-1:0] pulse;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Reference model: a channel is "active" from wake start until
  // shutdown; wake_left counts edges to ack, hold_left counts edges
  // to shutdown (-1 when no shutdown is pending).
  logic [NCH-1:0] hist[$];
  bit active[NCH];
  bit m_ack[NCH];
  int wake_left[NCH];
  int hold_left[NCH];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_front('0);
    for (int i = 0; i < NCH; i++) begin
      active[i] = 0;
      m_ack[i] = 0;
      wake_left[i] = 0;
      hold_left[i] = -1;
    end
  endtask

  task automatic model_edge(
    input logic [NCH-1:0] r, input logic scan,
    input int hv, output exp_t e);
    logic [NCH-1:0] rs;
    hist.push_front(r);
    rs = hist[SS];
    void'(hist.pop_back());
    e.idle = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      e.pulse[i] = active[i] | scan;
      if (!active[i]) begin
        if (rs[i]) begin
          active[i] = 1;
          wake_left[i] = WC;
        end
      end else if (wake_left[i] > 0) begin
        wake_left[i]--;
        if (wake_left[i] == 0) m_ack[i] = 1;
      end else if (hold_left[i] < 0) begin
        if (!rs[i]) hold_left[i] = hv + 1;
      end else if (rs[i]) begin
        hold_left[i] = -1;
      end else begin
        hold_left[i]--;
        if (hold_left[i] == 0) begin
          active[i] = 0;
          m_ack[i] = 0;
          hold_left[i] = -1;
        end
      end
      e.ack[i] = m_ack[i];
      if (active[i]) e.idle = 1'b0;
    end
  endtask

  // one clock: model the edge, queue the expectation, return at negedge
  task automatic step();
    exp_t e;
    @(posedge clk_in);
    if (rst_n) begin
      model_edge(req, scanen, int'(hold_val), e);
      sbq.push_back(e);
    end
    @(negedge clk_in);
  endtask

  int edges[NCH];
  int snap[NCH];
  logic [NCH-1:0] prev_co = '0;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      edges[i] = 0;
      snap[i] = 0;
    end
  end

  always @(clk_out) begin
    for (int i = 0; i < NCH; i++) begin
      if (clk_out[i] && !prev_co[i]) begin
        edges[i]++;
        chk($sformatf("glitch_ch%0d", i), int'(clk_in), 1);
      end
    end
    prev_co = clk_out;
  end

  always @(posedge clk_in) begin
    exp_t e;
    int d;
    #1;
    if (rst_n && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ack", int'(ack), int'(e.ack));
      chk("all_idle", int'(all_idle), int'(e.idle));
      for (int i = 0; i < NCH; i++) begin
        d = edges[i] - snap[i];
        chk($sformatf("pulse_ch%0d", i), d, int'(e.pulse[i]));
      end
    end
    for (int i = 0; i < NCH; i++) snap[i] = edges[i];
  end

  initial begin
    int first_ack, first_edge, n, base, dropped;
    int bases[NCH];
    model_reset();
    req = '1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_all_idle", int'(all_idle), 1);
    @(negedge clk_in);
    rst_n = 1'b1;

    first_ack = -1;
    first_edge = -1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (first_ack < 0 && ack[0]) first_ack = e;
      if (first_edge < 0 && edges[0] > 0) first_edge = e;
    end
    chk("ch0_first_clk_edge", first_edge, 4);
    chk("ch0_ack_edge", first_ack, 5);

    hold_val = 8'd5;
    req[1] = 1'b0;
    base = edges[1];
    n = 0;
    do begin
      step();
      n++;
    end while (ack[1] && n < 40);
    chk("ch1_ack_fall_edge", n, 9);
    chk("ch1_pulses", edges[1] - base, 9);
    repeat (5) step();
    chk("ch1_no_more_pulses", edges[1] - base, 9);

    hold_val = 8'd10;
    req[2] = 1'b0;
    base = edges[2];
    dropped = 0;
    for (int e = 1; e <= 13; e++) begin
      if (e == 6) req[2] = 1'b1;
      step();
      if (!ack[2]) dropped = 1;
    end
    chk("ch2_ack_held", dropped, 0);
    chk("ch2_continuous", edges[2] - base, 13);

    hold_val = 8'd0;
    req[3] = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (ack[3] && n < 40);
    chk("ch3_hold0_fall_edge", n, 4);

    req[3] = 1'b1;
    step();
    req[3] = 1'b0;
    repeat (12) step();

    req = '0;
    n = 0;
    while (!all_idle && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", int'(all_idle), 1);

    scanen = 1'b1;
    for (int i = 0; i < NCH; i++) bases[i] = edges[i];
    repeat (6) step();
    chk("scan_ack", int'(ack), 0);
    chk("scan_all_idle", int'(all_idle), 1);
    scanen = 1'b0;
    repeat (4) step();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("scan_pulses_ch%0d", i), edges[i] - bases[i], 6);
    end

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      end
      if ($urandom_range(31) == 0) hold_val = HW'($urandom_range(6));
      scanen = ($urandom_range(15) == 0);
      step();
    end
    scanen = 1'b0;

    req = '1;
    repeat (12) step();
    hold_val = '1;
    req[0] = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (ack[0] && n < 400);
    chk("ch0_max_hold_fall_edge", n, SS + 2 + 255);

    req = '1;
    repeat (10) step();
    @(posedge clk_in);
    begin
      exp_t e;
      model_edge(req, scanen, int'(hold_val), e);
      sbq.push_back(e);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_clk_out", int'(clk_out), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_all_idle", int'(all_idle), 1);
    model_reset();
    sbq.delete();
    repeat (2) @(negedge clk_in);
    chk("midrst_held_clk_out", int'(clk_out), 0);
    rst_n = 1'b1;
    repeat (12) step();
    chk("rewake_ack", int'(ack), 15);
    req = '0;
    repeat (20) step();
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
